// File: rtl/tcdm_tx_if_pkg.sv
// Shared types for the mini DMA TX-side TCDM interface.
// Tag and buffered-entry layouts used by the issue and response paths.
package tcdm_tx_if_pkg;

  localparam int unsigned SID_W  = 2;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic             eop;
    logic [SID_W-1:0] sid;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    tag_t              tag;
  } entry_t;

  localparam int unsigned TAG_W   = $bits(tag_t);
  localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/generic_fifo_ipa.sv
// Small synchronous FIFO, power-of-two depth.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module generic_fifo_ipa #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tcdm_tx_if_ipa.sv
// TX-side TCDM interface: issues reads, buffers data in order, feeds TX stream.
// Option TCDM_TX_IF_BYPASS_EN: zero-latency response path when buffer is empty.
module tcdm_tx_if_ipa
  import tcdm_tx_if_pkg::*;
#(
  parameter int unsigned TRANS_SID_WIDTH = SID_W,
  parameter int unsigned TCDM_ADD_WIDTH  = 12,
  parameter int unsigned BUF_DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       beat_eop_i,
  input  logic [TRANS_SID_WIDTH-1:0] beat_sid_i,
  input  logic [TCDM_ADD_WIDTH-1:0]  beat_add_i,
  input  logic                       beat_we_ni,
  input  logic                       beat_req_i,
  output logic                       beat_gnt_o,
  output logic                       synch_req_o,
  output logic [TRANS_SID_WIDTH-1:0] synch_sid_o,
  output logic [31:0]                tx_data_dat_o,
  output logic                       tx_data_valid_o,
  input  logic                       tx_data_ready_i,
  output logic                       tcdm_req_o,
  output logic [31:0]                tcdm_add_o,
  output logic                       tcdm_we_o,
  output logic [31:0]                tcdm_wdata_o,
  output logic [3:0]                 tcdm_be_o,
  input  logic                       tcdm_gnt_i,
  input  logic [31:0]                tcdm_r_rdata_i,
  input  logic                       tcdm_r_valid_i
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  tag_t          tag_in, tag_head;
  entry_t        ent_in, fifo_head, head;
  logic          tag_full, tag_empty;
  logic          dat_full, dat_empty;
  logic          rsp_ok, dat_push, dat_pop;
  logic          tx_valid, tx_pop;
  logic          unused_full;

  assign unused_full = tag_full ^ dat_full;

  // Credits cover outstanding reads plus buffered words.
  assign tcdm_req_o = rst_ni & beat_req_i & beat_we_ni
                    & (cnt_q < CW'(BUF_DEPTH));
  assign beat_gnt_o = tcdm_req_o & tcdm_gnt_i;

  assign tcdm_add_o   = {{(32-TCDM_ADD_WIDTH){1'b0}}, beat_add_i};
  assign tcdm_we_o    = beat_we_ni;
  assign tcdm_be_o    = 4'hF;
  assign tcdm_wdata_o = '0;

  assign tag_in = '{eop: beat_eop_i, sid: beat_sid_i};
  assign rsp_ok = tcdm_r_valid_i & ~tag_empty;
  assign ent_in = '{data: tcdm_r_rdata_i, tag: tag_head};

`ifdef TCDM_TX_IF_BYPASS_EN
  logic byp;
  assign byp      = dat_empty & rsp_ok;
  assign head     = byp ? ent_in : fifo_head;
  assign tx_valid = ~dat_empty | byp;
  assign dat_push = rsp_ok & ~(byp & tx_data_ready_i);
`else
  assign head     = fifo_head;
  assign tx_valid = ~dat_empty;
  assign dat_push = rsp_ok;
`endif

  assign tx_pop  = tx_valid & tx_data_ready_i;
  assign dat_pop = tx_pop & ~dat_empty;

  assign tx_data_valid_o = tx_valid;
  assign tx_data_dat_o   = tx_valid ? head.data : '0;
  assign synch_req_o     = tx_pop & head.tag.eop;
  assign synch_sid_o     = synch_req_o ? head.tag.sid : '0;

  generic_fifo_ipa #(
    .DATA_WIDTH (TAG_W),
    .DEPTH      (BUF_DEPTH)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (beat_gnt_o),
    .pop_i   (rsp_ok),
    .data_i  (tag_in),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  generic_fifo_ipa #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (BUF_DEPTH)
  ) i_dat_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (dat_push),
    .pop_i   (dat_pop),
    .data_i  (ent_in),
    .data_o  (fifo_head),
    .full_o  (dat_full),
    .empty_o (dat_empty)
  );

  // Credit update: grant adds, TX handoff returns.
  always_comb begin
    cnt_d = cnt_q;
    case ({beat_gnt_o, tx_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Credit counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tcdm_tx_if_ipa.sv
// Directed and scoreboard bench for tcdm_tx_if_ipa (default build).
// Manual drive for cycle-exact cases, a small TCDM/queue model otherwise.
module tb_tcdm_tx_if_ipa;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        bfm_on;
  logic        m_eop, m_we_n, m_req, m_gnt, m_rvalid, m_ready;
  logic [1:0]  m_sid;
  logic [11:0] m_add;
  logic [31:0] m_rdata;
  logic        b_eop, b_req, b_gnt, b_rvalid, b_ready;
  logic [1:0]  b_sid;
  logic [11:0] b_add;
  logic [31:0] b_rdata;

  logic        beat_eop, beat_we_n, beat_req, tcdm_gnt;
  logic        tcdm_rvalid, tx_data_ready;
  logic [1:0]  beat_sid;
  logic [11:0] beat_add;
  logic [31:0] tcdm_rdata;

  assign beat_eop      = bfm_on ? b_eop : m_eop;
  assign beat_sid      = bfm_on ? b_sid : m_sid;
  assign beat_add      = bfm_on ? b_add : m_add;
  assign beat_we_n     = bfm_on ? 1'b1 : m_we_n;
  assign beat_req      = bfm_on ? b_req : m_req;
  assign tcdm_gnt      = bfm_on ? b_gnt : m_gnt;
  assign tcdm_rvalid   = bfm_on ? b_rvalid : m_rvalid;
  assign tcdm_rdata    = bfm_on ? b_rdata : m_rdata;
  assign tx_data_ready = bfm_on ? b_ready : m_ready;

  logic        beat_gnt_o, synch_req_o, tx_data_valid_o;
  logic        tcdm_req_o, tcdm_we_o;
  logic [1:0]  synch_sid_o;
  logic [31:0] tx_data_dat_o, tcdm_add_o, tcdm_wdata_o;
  logic [3:0]  tcdm_be_o;

  tcdm_tx_if_ipa dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .beat_eop_i      (beat_eop),
    .beat_sid_i      (beat_sid),
    .beat_add_i      (beat_add),
    .beat_we_ni      (beat_we_n),
    .beat_req_i      (beat_req),
    .beat_gnt_o      (beat_gnt_o),
    .synch_req_o     (synch_req_o),
    .synch_sid_o     (synch_sid_o),
    .tx_data_dat_o   (tx_data_dat_o),
    .tx_data_valid_o (tx_data_valid_o),
    .tx_data_ready_i (tx_data_ready),
    .tcdm_req_o      (tcdm_req_o),
    .tcdm_add_o      (tcdm_add_o),
    .tcdm_we_o       (tcdm_we_o),
    .tcdm_wdata_o    (tcdm_wdata_o),
    .tcdm_be_o       (tcdm_be_o),
    .tcdm_gnt_i      (tcdm_gnt),
    .tcdm_r_rdata_i  (tcdm_rdata),
    .tcdm_r_valid_i  (tcdm_rvalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {16'hC0DE, 4'h0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  typedef struct { logic [11:0] add; logic eop; logic [1:0] sid; } beat_t;
  typedef struct { logic [11:0] add; int due; } pend_t;
  typedef struct { logic [31:0] d; logic eop; logic [1:0] sid; } exp_t;

  beat_t beatq[$];
  pend_t pend[$];
  exp_t  expq[$];
  int    occ = 0, n_gnt = 0, n_pop = 0, cyc = 0;
  int    lat_max = 0;
  logic  gnt_rand = 1'b0, rdy_rand = 1'b0, rdy_force = 1'b0;
  logic  bg, rvt;

  task automatic wait_pops(input int n, input int lim, input string tag);
    int k = 0;
    while (n_pop < n && k < lim) begin
      tick();
      k++;
    end
    chk(tag, n_pop, n);
  endtask

  // Queue-side beat source, in-order TCDM responder and TX scoreboard.
  initial begin
    exp_t e;
    b_eop = 0; b_sid = 0; b_add = 0; b_req = 0;
    b_gnt = 0; b_rvalid = 0; b_rdata = 0; b_ready = 0;
    forever begin
      mid();
      bg  = 1'b0;
      rvt = 1'b0;
      if (bfm_on && rst_n) begin
        chk("issue", tcdm_req_o, beat_req && (occ < 4));
        if (beat_gnt_o) begin
          expq.push_back('{d: mem_word(beat_add), eop: beat_eop,
                           sid: beat_sid});
          pend.push_back('{add: tcdm_add_o[11:0],
                           due: cyc + 1 + int'($urandom_range(0, lat_max))});
          n_gnt++;
          occ++;
          bg = 1'b1;
        end
        if (tx_data_valid_o && tx_data_ready) begin
          if (expq.size() == 0) begin
            chk("tx_extra", n_pop + 1, n_gnt);
          end else begin
            e = expq.pop_front();
            chk("tx_dat", tx_data_dat_o, e.d);
            chk("synch", synch_req_o, e.eop);
            if (e.eop) chk("synch_sid", synch_sid_o, e.sid);
          end
          n_pop++;
          occ--;
        end else begin
          chk("synch_idle", synch_req_o, 0);
        end
        rvt = b_rvalid;
      end
      tick();
      cyc++;
      if (bg) void'(beatq.pop_front());
      if (rvt) void'(pend.pop_front());
      if (beatq.size() > 0) begin
        b_req = 1'b1;
        b_add = beatq[0].add;
        b_eop = beatq[0].eop;
        b_sid = beatq[0].sid;
      end else begin
        b_req = 1'b0;
      end
      b_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        b_rvalid = 1'b1;
        b_rdata  = mem_word(pend[0].add);
      end else begin
        b_rvalid = 1'b0;
        b_rdata  = '0;
      end
      b_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bfm_on = 0; rst_n = 0;
    m_eop = 0; m_we_n = 1; m_req = 1; m_gnt = 1; m_rvalid = 0;
    m_ready = 0; m_sid = 0; m_add = 12'h3FF; m_rdata = 0;

    // reset values, even with a beat presented
    repeat (2) tick();
    mid();
    chk("rst_req", tcdm_req_o, 0);
    chk("rst_bgnt", beat_gnt_o, 0);
    chk("rst_valid", tx_data_valid_o, 0);
    chk("rst_dat", tx_data_dat_o, 0);
    chk("rst_synch", synch_req_o, 0);
    chk("rst_sid", synch_sid_o, 0);
    tick();
    rst_n = 1; m_req = 0; m_gnt = 0;

    // single 1-beat transaction
    tick();
    m_req = 1; m_we_n = 1; m_sid = 2; m_eop = 1; m_add = 12'h010;
    m_gnt = 1; m_ready = 1;
    mid();
    chk("t1_req", tcdm_req_o, 1);
    chk("t1_bgnt", beat_gnt_o, 1);
    chk("t1_add", tcdm_add_o, 32'h10);
    chk("t1_we", tcdm_we_o, 1);
    chk("t1_be", tcdm_be_o, 4'hF);
    chk("t1_wdata", tcdm_wdata_o, 0);
    tick();
    m_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    mid();
    chk("t1_lat", tx_data_valid_o, 0);
    tick();
    m_rvalid = 0; m_rdata = 0;
    mid();
    chk("t1_valid", tx_data_valid_o, 1);
    chk("t1_dat", tx_data_dat_o, 32'hDEADBEEF);
    chk("t1_synch", synch_req_o, 1);
    chk("t1_sid", synch_sid_o, 2);
    tick();
    mid();
    chk("t1_empty", tx_data_valid_o, 0);
    chk("t1_synch0", synch_req_o, 0);
    chk("t1_dat0", tx_data_dat_o, 0);

    // grant stall
    tick();
    m_req = 1; m_add = 12'h2A5; m_sid = 1; m_eop = 1; m_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("gs_req", tcdm_req_o, 1);
      chk("gs_bgnt", beat_gnt_o, 0);
      chk("gs_add", tcdm_add_o, 32'h2A5);
      tick();
    end
    m_gnt = 1;
    mid();
    chk("gs_bgnt1", beat_gnt_o, 1);
    tick();
    m_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h12345678;
    tick();
    m_rvalid = 0;
    mid();
    chk("gs_dat", tx_data_dat_o, 32'h12345678);
    chk("gs_synch", synch_req_o, 1);
    chk("gs_sid", synch_sid_o, 1);

    // write beat is never requested
    tick();
    m_req = 1; m_we_n = 0; m_gnt = 1;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("wr_req", tcdm_req_o, 0);
      chk("wr_bgnt", beat_gnt_o, 0);
      tick();
    end
    m_req = 0; m_we_n = 1; m_gnt = 0;

    // back-pressure: 6 beats, consumer stalled
    gnt_rand = 0; lat_max = 0; rdy_rand = 0; rdy_force = 0;
    n_gnt = 0; n_pop = 0; occ = 0;
    bfm_on = 1;
    for (int i = 0; i < 6; i++)
      beatq.push_back('{add: 12'(12'h100 + i), eop: (i == 5), sid: 2'd3});
    repeat (12) tick();
    mid();
    chk("bp_gnts", n_gnt, 4);
    chk("bp_req", tcdm_req_o, 0);
    chk("bp_valid", tx_data_valid_o, 1);
    rdy_force = 1;
    wait_pops(6, 60, "bp_drain");
    chk("bp_gnts_all", n_gnt, 6);

    // random grant/latency/ready with scoreboard
    gnt_rand = 1; lat_max = 3; rdy_rand = 1;
    n_gnt = 0; n_pop = 0;
    for (int i = 0; i < 200; i++)
      beatq.push_back('{add: 12'($urandom_range(0, 4095)),
                        eop: (i == 199) || ($urandom_range(0, 3) == 0),
                        sid: 2'($urandom_range(0, 3))});
    wait_pops(200, 5000, "rnd_drain");
    chk("rnd_gnts", n_gnt, 200);
    tick();
    bfm_on = 0;

    // reset with two outstanding reads
    m_req = 1; m_we_n = 1; m_add = 12'h040; m_sid = 0; m_eop = 0;
    m_gnt = 1; m_ready = 0; m_rvalid = 0;
    tick();
    m_add = 12'h041; m_eop = 1;
    tick();
    m_req = 0; m_gnt = 0; rst_n = 0;
    mid();
    chk("mr_req", tcdm_req_o, 0);
    chk("mr_bgnt", beat_gnt_o, 0);
    chk("mr_valid", tx_data_valid_o, 0);
    chk("mr_dat", tx_data_dat_o, 0);
    chk("mr_synch", synch_req_o, 0);
    chk("mr_sid", synch_sid_o, 0);
    tick();
    rst_n = 1; m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
    mid();
    chk("mr_late0", tx_data_valid_o, 0);
    tick();
    m_rvalid = 0;
    mid();
    chk("mr_late1", tx_data_valid_o, 0);
    tick();
    m_req = 1; m_add = 12'h077; m_sid = 1; m_eop = 1; m_gnt = 1;
    mid();
    chk("mr_bgnt1", beat_gnt_o, 1);
    tick();
    m_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000C0DE;
    tick();
    m_rvalid = 0; m_ready = 1;
    mid();
    chk("mr_valid1", tx_data_valid_o, 1);
    chk("mr_dat1", tx_data_dat_o, 32'h0000C0DE);
    chk("mr_synch1", synch_req_o, 1);
    chk("mr_sid1", synch_sid_o, 1);
    tick();
    mid();
    chk("mr_synch_once", synch_req_o, 0);
    chk("mr_empty", tx_data_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
